// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master) and imem (slave).
interface if_fetch_stage_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              imemReq;
   logic [ADDR_W-1:0] imemAddr;
   logic              imemReady;
   logic [INST_W-1:0] imemData;

   modport master (output imemReq, imemAddr, input imemReady, imemData);
   modport slave  (input imemReq, imemAddr, output imemReady, imemData);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, one outstanding imem request, feeds the IF/ID register.
// Optional macro IF_ALIGN_CHECK_EN adds a sticky misalign_o flag and word-aligns redirect targets.
//
// state | meaning
// FETCH | request at pc outstanding; deliver or redirect on completion
// HOLD  | stalled with fetched word buffered; no request
// KILL  | in-flight request must complete, its data is dropped, then jump to redir
module if_fetch_stage #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              brTaken_i,
   input  logic [ADDR_W-1:0] brTarget_i,
   if_fetch_stage_if.master  imem,
   output logic [ADDR_W-1:0] ifPC_o,
   output logic [INST_W-1:0] ifInst_o,
`ifdef IF_ALIGN_CHECK_EN
   output logic              misalign_o,
`endif
   output logic              ifValid_o
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_HOLD  = 2'd1;
   localparam logic [1:0] S_KILL  = 2'd2;

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] redir_q, redir_d;
   logic [INST_W-1:0] buf_q, buf_d;
   logic [ADDR_W-1:0] ifpc_q, ifpc_d;
   logic [INST_W-1:0] ifinst_q, ifinst_d;
   logic              ifvalid_q, ifvalid_d;
   logic [ADDR_W-1:0] target;
   logic              deliver;
   logic [INST_W-1:0] deliver_inst;

`ifdef IF_ALIGN_CHECK_EN
   logic misalign_q, misalign_d;
   assign target     = {brTarget_i[ADDR_W-1:2], 2'b00};
   assign misalign_d = misalign_q | (brTaken_i & (brTarget_i[1:0] != 2'b00));
   assign misalign_o = misalign_q;
`else
   assign target = brTarget_i;
`endif

   // Gated by rst so the request drops the instant reset asserts.
   assign imem.imemReq  = rst & (state_q != S_HOLD);
   assign imem.imemAddr = pc_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      redir_d      = redir_q;
      buf_d        = buf_q;
      deliver      = 1'b0;
      deliver_inst = imem.imemData;
      unique case (state_q)
         S_FETCH: begin
            if (imem.imemReady) begin
               if (brTaken_i) begin
                  pc_d = target;
               end else if (!stall_i) begin
                  deliver = 1'b1;
                  pc_d    = pc_q + PC_STEP;
               end else begin
                  buf_d   = imem.imemData;
                  state_d = S_HOLD;
               end
            end else if (brTaken_i) begin
               redir_d = target;
               state_d = S_KILL;
            end
         end
         S_HOLD: begin
            if (brTaken_i) begin
               pc_d    = target;
               state_d = S_FETCH;
            end else if (!stall_i) begin
               deliver      = 1'b1;
               deliver_inst = buf_q;
               pc_d         = pc_q + PC_STEP;
               state_d      = S_FETCH;
            end
         end
         S_KILL: begin
            if (brTaken_i) redir_d = target;
            if (imem.imemReady) begin
               pc_d    = brTaken_i ? target : redir_q;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase

      if (deliver) begin
         ifpc_d    = pc_q;
         ifinst_d  = deliver_inst;
         ifvalid_d = 1'b1;
      end else if (stall_i) begin
         ifpc_d    = ifpc_q;
         ifinst_d  = ifinst_q;
         ifvalid_d = ifvalid_q;
      end else begin
         ifpc_d    = pc_q;
         ifinst_d  = '0;
         ifvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         redir_q   <= '0;
         buf_q     <= '0;
         ifpc_q    <= '0;
         ifinst_q  <= '0;
         ifvalid_q <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         redir_q   <= redir_d;
         buf_q     <= buf_d;
         ifpc_q    <= ifpc_d;
         ifinst_q  <= ifinst_d;
         ifvalid_q <= ifvalid_d;
`ifdef IF_ALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   assign ifPC_o    = ifpc_q;
   assign ifInst_o  = ifinst_q;
   assign ifValid_o = ifvalid_q;

endmodule
